reset_shutdown_sequencer: RTL and testbench
===========================================

Name: reset_shutdown_sequencer

Overview:
Two-way reset sequencer for the board's staged reset domains. It releases per-domain resets in forward order (0..N-1) with a fixed cycle gap, the same power-up behaviour downstream logic already expects. On request it performs the opposite direction: orderly shutdown in reverse order (N-1..0). Before each domain's reset is re-asserted, it waits for that domain's quiesce acknowledge, with a timeout. It sits between the board reset pin synchronizer and all staged-reset consumers, and lets software power-cycle subsystems without a full board reset.

Parameters:
STAGES, 3, number of reset domains (>=1)
CNT_W, 32, width of the gap and timeout counter
GAP_CYC, 32'h1FFFFF, cycles between consecutive stage releases or assertions (>=1)
TIMEOUT_CYC, 32'hFFFFFF, max cycles to wait for iQUIESCE[k] (>=1)

Ports:
iCLK  in  1  system clock
iRST  in  1  asynchronous active-high reset
iSHDN_REQ  in  1  shutdown request, level-sampled, acted on only in RUN
iUP_REQ  in  1  power-up request, level-sampled, acted on only in OFF
iQUIESCE  in  STAGES  per-domain idle acknowledge, bit k from domain k
oRST  out  STAGES  per-domain reset, active-low (0 = domain held in reset)
oBUSY  out  1  high in UP, QUIESCE and HOLD
oDONE  out  1  one-cycle pulse when a sequence completes
oTIMEOUT  out  STAGES  sticky, bit k set when domain k failed to quiesce in time
oSTATE  out  3  current FSM state encoding, for debug

Behaviour:
- iRST=1, asynchronous: oRST=0, oDONE=0, oTIMEOUT=0, counter=0, k=0, state=UP. oBUSY follows state (1 in UP).
- After iRST deasserts, the power-up sequence starts automatically. No request is needed.
- UP: counter increments every cycle.
  - When counter==GAP_CYC-1: oRST[k]<=1, counter<=0, k<=k+1.
  - Stage k therefore rises on the (k+1)*GAP_CYC-th edge after reset release.
  - On the edge releasing stage STAGES-1: oDONE<=1 for that cycle, state<=RUN.
- RUN: oBUSY=0. If iSHDN_REQ=1: k<=STAGES-1, counter<=0, state<=QUIESCE.
- QUIESCE: counter increments every cycle.
  - If iQUIESCE[k]=1: oRST[k]<=0, counter<=0, state<=HOLD.
  - Else if counter==TIMEOUT_CYC-1: oTIMEOUT[k]<=1, oRST[k]<=0, counter<=0, state<=HOLD.
  - If both conditions hold in the same cycle, the ack wins and no timeout flag is set.
  - The ack is sampled no earlier than the cycle after entering QUIESCE.
- HOLD: counter increments every cycle. When counter==GAP_CYC-1:
  - if k==0: oDONE pulse, state<=OFF;
  - else: k<=k-1, counter<=0, state<=QUIESCE.
- OFF: oRST all 0. If iUP_REQ=1: k<=0, counter<=0, oTIMEOUT<=0, state<=UP.
- Requests are ignored outside their state and are never queued:
  - iSHDN_REQ during UP has no effect; the power-up sequence completes.
  - A request held high is re-acted on when the FSM next enters the accepting state.
- iSHDN_REQ and iUP_REQ high together: only the one valid in the current state matters.
- iRST mid-sequence: immediate return to the reset values and restart of power-up. Any in-progress shutdown is abandoned.
- Counter compares are exact equality. The counter never exceeds max(GAP_CYC, TIMEOUT_CYC)-1, so no wrap occurs.
- oRST, oDONE, oTIMEOUT and oSTATE are all registered outputs. No combinational path from inputs to outputs.

Decomposition:
- Package reset_seq_pkg holds:
  - state typedef enum {UP, RUN, QUIESCE, HOLD, OFF}, 3-bit;
  - the default GAP_CYC and TIMEOUT_CYC constants.
- One sub-module, reset_seq_timer: CNT_W counter with synchronous clear and a terminal-count compare against a runtime-selected limit (GAP_CYC or TIMEOUT_CYC).

Test Plan:
1. STAGES=3, GAP_CYC=4: release iRST → oRST goes 001 at edge 4, 011 at edge 8, 111 at edge 12; oDONE high only in the cycle after edge 12; oBUSY=0 afterwards.
2. From RUN, pulse iSHDN_REQ and return iQUIESCE[2] 2 cycles later, then [1] and [0] immediately → oRST goes 011, then 001, then 000, with 4-cycle HOLD gaps; oDONE pulse on entering OFF; oTIMEOUT=000.
3. TIMEOUT_CYC=8, iQUIESCE held 0 → each stage asserts after 8 QUIESCE cycles plus 4 HOLD cycles; oTIMEOUT=111 at the end; a later iUP_REQ clears it to 000.
4. iQUIESCE[k] rising on the same cycle as the timeout terminal count → stage asserts, oTIMEOUT[k] stays 0.
5. iSHDN_REQ held high throughout power-up → ignored until RUN, then shutdown starts on the first RUN cycle; iUP_REQ in RUN has no effect.
6. Assert iRST during HOLD at k=1 → oRST=000 immediately (asynchronous), oTIMEOUT=000; after release, power-up timing is identical to scenario 1.

Source files
------------

// File: rtl/reset_shutdown_sequencer_pkg.sv
// Shared types and default timing constants for the staged reset sequencer.
package reset_seq_pkg;

  // Sequencer states; the encoding is exported on oSTATE for debug.
  typedef enum logic [2:0] {
    UP      = 3'd0,
    RUN     = 3'd1,
    QUIESCE = 3'd2,
    HOLD    = 3'd3,
    OFF     = 3'd4
  } state_e;

  // Default gap between stage transitions and default quiesce timeout, in cycles.
  localparam logic [31:0] DEF_GAP_CYC     = 32'h001F_FFFF;
  localparam logic [31:0] DEF_TIMEOUT_CYC = 32'h00FF_FFFF;

endpackage

// File: rtl/reset_shutdown_sequencer_if.sv
// Request, acknowledge and status signals between the staged-reset
// sequencer (slave) and the controlling/consuming side (master).
interface reset_shutdown_sequencer_if #(
  parameter int unsigned STAGES = 3
);

  logic              iSHDN_REQ;
  logic              iUP_REQ;
  logic [STAGES-1:0] iQUIESCE;
  logic [STAGES-1:0] oRST;
  logic              oBUSY;
  logic              oDONE;
  logic [STAGES-1:0] oTIMEOUT;
  logic [2:0]        oSTATE;

  modport master (
    output iSHDN_REQ, iUP_REQ, iQUIESCE,
    input  oRST, oBUSY, oDONE, oTIMEOUT, oSTATE
  );

  modport slave (
    input  iSHDN_REQ, iUP_REQ, iQUIESCE,
    output oRST, oBUSY, oDONE, oTIMEOUT, oSTATE
  );

endinterface

// File: rtl/reset_shutdown_sequencer_timer.sv
// Shared gap/timeout counter: synchronous clear, count enable, and a
// terminal-count flag against either the gap or the timeout limit.
module reset_seq_timer #(
  parameter int unsigned       CNT_W       = 32,
  parameter logic [CNT_W-1:0]  GAP_CYC     = 4,
  parameter logic [CNT_W-1:0]  TIMEOUT_CYC = 8
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic clr_i,
  input  logic en_i,
  input  logic sel_timeout_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] GAP_LAST     = GAP_CYC - 1'b1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CYC - 1'b1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // Exact-equality terminal count; the counter is cleared before it can pass it.
  assign tc_o = (cnt_q == (sel_timeout_i ? TIMEOUT_LAST : GAP_LAST));

endmodule

// File: rtl/reset_shutdown_sequencer.sv
// Staged reset sequencer: releases domain resets 0..N-1 after reset, and on
// request shuts them down N-1..0, waiting for each quiesce ack or a timeout.
module reset_shutdown_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned      STAGES      = 3,
  parameter int unsigned      CNT_W       = 32,
  parameter logic [CNT_W-1:0] GAP_CYC     = CNT_W'(DEF_GAP_CYC),
  parameter logic [CNT_W-1:0] TIMEOUT_CYC = CNT_W'(DEF_TIMEOUT_CYC)
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  reset_shutdown_sequencer_if.slave   bus
);

  localparam int unsigned      K_W    = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [K_W-1:0]   K_LAST = K_W'(STAGES - 1);

  state_e            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [STAGES-1:0] rst_q, rst_d;
  logic [STAGES-1:0] tmo_q, tmo_d;
  logic              done_q, done_d;

  logic tmr_clr, tmr_en, tmr_sel_tmo, tmr_tc;
  logic ack;

  assign ack = bus.iQUIESCE[k_q];

  reset_seq_timer #(
    .CNT_W       (CNT_W),
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .iCLK          (iCLK),
    .iRST          (iRST),
    .clr_i         (tmr_clr),
    .en_i          (tmr_en),
    .sel_timeout_i (tmr_sel_tmo),
    .tc_o          (tmr_tc)
  );

  // State and registered-output storage; reset restarts power-up.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= UP;
      k_q     <= '0;
      rst_q   <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rst_q   <= rst_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
    end
  end

  // Next-state selection.
  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UP:      if (tmr_tc && (k_q == K_LAST)) state_d = RUN;
      RUN:     if (bus.iSHDN_REQ)             state_d = QUIESCE;
      QUIESCE: if (ack || tmr_tc)             state_d = HOLD;
      HOLD:    if (tmr_tc)                    state_d = (k_q == '0) ? OFF : QUIESCE;
      OFF:     if (bus.iUP_REQ)               state_d = UP;
      default:                                state_d = UP;
    endcase
  end

  // Stage index, reset/timeout vectors, done pulse and timer control.
  always_comb begin
    k_d         = k_q;
    rst_d       = rst_q;
    tmo_d       = tmo_q;
    done_d      = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    tmr_sel_tmo = 1'b0;
    unique case (state_q)
      UP: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          rst_d[k_q] = 1'b1;
          tmr_clr    = 1'b1;
          if (k_q == K_LAST) done_d = 1'b1;
          else               k_d    = k_q + 1'b1;
        end
      end
      RUN: begin
        if (bus.iSHDN_REQ) begin
          k_d     = K_LAST;
          tmr_clr = 1'b1;
        end
      end
      QUIESCE: begin
        tmr_en      = 1'b1;
        tmr_sel_tmo = 1'b1;
        // The ack wins over a coincident timeout.
        if (ack) begin
          rst_d[k_q] = 1'b0;
          tmr_clr    = 1'b1;
        end else if (tmr_tc) begin
          tmo_d[k_q] = 1'b1;
          rst_d[k_q] = 1'b0;
          tmr_clr    = 1'b1;
        end
      end
      HOLD: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          tmr_clr = 1'b1;
          if (k_q == '0) done_d = 1'b1;
          else           k_d    = k_q - 1'b1;
        end
      end
      OFF: begin
        rst_d = '0;
        if (bus.iUP_REQ) begin
          k_d     = '0;
          tmo_d   = '0;
          tmr_clr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.oRST     = rst_q;
  assign bus.oTIMEOUT = tmo_q;
  assign bus.oDONE    = done_q;
  assign bus.oSTATE   = state_q;
  assign bus.oBUSY    = (state_q == UP) || (state_q == QUIESCE) || (state_q == HOLD);

endmodule

// File: tb/tb_reset_shutdown_sequencer.sv
// Scoreboard bench: stimulus pushes expected oRST/oDONE/oTIMEOUT events with
// their edge numbers; a negedge monitor pops one per observed event.
module tb_reset_shutdown_sequencer;

  localparam int unsigned STAGES = 3;

  typedef struct {
    int         at;
    logic [2:0] rst;
    logic       done;
    logic [2:0] tmo;
  } exp_t;

  logic clk;
  logic rst;
  int   edge_cnt;
  int   total;
  int   bad;
  bit   mon_en;
  logic [2:0] prev_rst;
  exp_t sb[$];

  reset_shutdown_sequencer_if #(.STAGES(STAGES)) bus ();

  reset_shutdown_sequencer #(
    .STAGES      (STAGES),
    .CNT_W       (32),
    .GAP_CYC     (32'd4),
    .TIMEOUT_CYC (32'd8)
  ) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    edge_cnt = 0;
    forever begin
      @(posedge clk);
      edge_cnt = edge_cnt + 1;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic push(input int at, input logic [2:0] r, input logic d, input logic [2:0] t);
    exp_t e;
    e.at = at; e.rst = r; e.done = d; e.tmo = t;
    sb.push_back(e);
  endtask

  // Advance to just after the given posedge (inputs change 2 time units after it).
  task automatic go_to(input int e);
    while (edge_cnt < e) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: any oRST change or oDONE pulse is an event matched against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if ((bus.oRST !== prev_rst) || (bus.oDONE === 1'b1)) begin
          total = total + 1;
          if (sb.size() == 0) begin
            bad = bad + 1;
            $display("FAIL unexpected_event: edge=%0d rst=%b done=%b tmo=%b, none expected",
                     edge_cnt, bus.oRST, bus.oDONE, bus.oTIMEOUT);
          end else begin
            e = sb.pop_front();
            if ((edge_cnt != e.at) || (bus.oRST !== e.rst) || (bus.oDONE !== e.done) ||
                (bus.oTIMEOUT !== e.tmo)) begin
              bad = bad + 1;
              $display("FAIL event: got edge=%0d rst=%b done=%b tmo=%b, expected edge=%0d rst=%b done=%b tmo=%b",
                       edge_cnt, bus.oRST, bus.oDONE, bus.oTIMEOUT, e.at, e.rst, e.done, e.tmo);
            end
          end
        end
        prev_rst = bus.oRST;
      end
    end
  end

  initial begin
    int t;
    int u;
    total = 0; bad = 0; mon_en = 0; prev_rst = 3'b000;
    rst = 1'b0;
    bus.iSHDN_REQ = 1'b0; bus.iUP_REQ = 1'b0; bus.iQUIESCE = 3'b000;
    #1 rst = 1'b1;
    go_to(2);

    // Reset state
    check("rst_oRST",     32'(bus.oRST),     32'h0);
    check("rst_oDONE",    32'(bus.oDONE),    32'h0);
    check("rst_oTIMEOUT", 32'(bus.oTIMEOUT), 32'h0);
    check("rst_oBUSY",    32'(bus.oBUSY),    32'h1);
    check("rst_oSTATE",   32'(bus.oSTATE),   32'h0);
    prev_rst = 3'b000;
    mon_en = 1;

    // 1: automatic power-up after reset release
    t = edge_cnt;
    rst = 1'b0;
    push(t + 4, 3'b001, 1'b0, 3'b000);
    push(t + 8, 3'b011, 1'b0, 3'b000);
    push(t + 12, 3'b111, 1'b1, 3'b000);
    go_to(t + 13);
    check("run_busy",  32'(bus.oBUSY),  32'h0);
    check("run_state", 32'(bus.oSTATE), 32'h1);
    // Power-up request in RUN is ignored
    bus.iUP_REQ = 1'b1;
    go_to(t + 16);
    bus.iUP_REQ = 1'b0;
    check("run_upreq_ignored", 32'(bus.oSTATE), 32'h1);

    // 2: shutdown with acknowledges
    t = edge_cnt;
    bus.iSHDN_REQ = 1'b1;
    push(t + 3, 3'b011, 1'b0, 3'b000);
    push(t + 8, 3'b001, 1'b0, 3'b000);
    push(t + 13, 3'b000, 1'b0, 3'b000);
    push(t + 17, 3'b000, 1'b1, 3'b000);
    go_to(t + 1); bus.iSHDN_REQ = 1'b0;
    go_to(t + 2); bus.iQUIESCE = 3'b100;
    go_to(t + 3); bus.iQUIESCE = 3'b111;
    go_to(t + 18);
    check("off_state", 32'(bus.oSTATE), 32'h4);
    check("off_busy",  32'(bus.oBUSY),  32'h0);
    bus.iQUIESCE = 3'b000;

    // 3: power-up by request, then shutdown with every domain timing out
    t = edge_cnt;
    bus.iUP_REQ = 1'b1;
    push(t + 5, 3'b001, 1'b0, 3'b000);
    push(t + 9, 3'b011, 1'b0, 3'b000);
    push(t + 13, 3'b111, 1'b1, 3'b000);
    go_to(t + 1); bus.iUP_REQ = 1'b0;
    go_to(t + 14);
    t = edge_cnt;
    bus.iSHDN_REQ = 1'b1;
    push(t + 9, 3'b011, 1'b0, 3'b100);
    push(t + 21, 3'b001, 1'b0, 3'b110);
    push(t + 33, 3'b000, 1'b0, 3'b111);
    push(t + 37, 3'b000, 1'b1, 3'b111);
    go_to(t + 1); bus.iSHDN_REQ = 1'b0;
    go_to(t + 20);
    check("tmo_quiesce_busy", 32'(bus.oBUSY), 32'h1);
    go_to(t + 38);
    check("tmo_sticky", 32'(bus.oTIMEOUT), 32'h7);
    t = edge_cnt;
    bus.iUP_REQ = 1'b1;
    push(t + 5, 3'b001, 1'b0, 3'b000);
    push(t + 9, 3'b011, 1'b0, 3'b000);
    push(t + 13, 3'b111, 1'b1, 3'b000);
    go_to(t + 1); bus.iUP_REQ = 1'b0;
    check("tmo_cleared", 32'(bus.oTIMEOUT), 32'h0);
    check("up_state",    32'(bus.oSTATE),   32'h0);
    go_to(t + 14);

    // 4: ack coincides with timeout terminal count on stage 2
    t = edge_cnt;
    bus.iSHDN_REQ = 1'b1;
    push(t + 9, 3'b011, 1'b0, 3'b000);
    push(t + 14, 3'b001, 1'b0, 3'b000);
    push(t + 19, 3'b000, 1'b0, 3'b000);
    push(t + 23, 3'b000, 1'b1, 3'b000);
    go_to(t + 1); bus.iSHDN_REQ = 1'b0;
    go_to(t + 8); bus.iQUIESCE = 3'b100;
    go_to(t + 9); bus.iQUIESCE = 3'b111;
    go_to(t + 24);
    check("ack_vs_tmo", 32'(bus.oTIMEOUT), 32'h0);

    // 5: both requests high in OFF; shutdown held through power-up
    t = edge_cnt;
    bus.iUP_REQ = 1'b1;
    bus.iSHDN_REQ = 1'b1;
    push(t + 5, 3'b001, 1'b0, 3'b000);
    push(t + 9, 3'b011, 1'b0, 3'b000);
    push(t + 13, 3'b111, 1'b1, 3'b000);
    push(t + 15, 3'b011, 1'b0, 3'b000);
    push(t + 20, 3'b001, 1'b0, 3'b000);
    push(t + 25, 3'b000, 1'b0, 3'b000);
    push(t + 29, 3'b000, 1'b1, 3'b000);
    go_to(t + 1); bus.iUP_REQ = 1'b0;
    go_to(t + 14);
    check("shdn_first_run_cycle", 32'(bus.oSTATE), 32'h2);
    bus.iSHDN_REQ = 1'b0;
    go_to(t + 30);

    // 6: reset during HOLD at k=1 after a stage-2 timeout
    t = edge_cnt;
    bus.iUP_REQ = 1'b1;
    push(t + 5, 3'b001, 1'b0, 3'b000);
    push(t + 9, 3'b011, 1'b0, 3'b000);
    push(t + 13, 3'b111, 1'b1, 3'b000);
    go_to(t + 1); bus.iUP_REQ = 1'b0;
    go_to(t + 14);
    t = edge_cnt;
    bus.iQUIESCE = 3'b011;
    bus.iSHDN_REQ = 1'b1;
    push(t + 9, 3'b011, 1'b0, 3'b100);
    push(t + 14, 3'b001, 1'b0, 3'b100);
    push(t + 16, 3'b000, 1'b0, 3'b000);
    go_to(t + 1); bus.iSHDN_REQ = 1'b0;
    go_to(t + 16);
    check("hold_before_rst", 32'(bus.oSTATE), 32'h3);
    rst = 1'b1;
    #1;
    check("async_oRST",     32'(bus.oRST),     32'h0);
    check("async_oTIMEOUT", 32'(bus.oTIMEOUT), 32'h0);
    check("async_oSTATE",   32'(bus.oSTATE),   32'h0);
    check("async_oBUSY",    32'(bus.oBUSY),    32'h1);
    go_to(t + 18);
    u = edge_cnt;
    rst = 1'b0;
    push(u + 4, 3'b001, 1'b0, 3'b000);
    push(u + 8, 3'b011, 1'b0, 3'b000);
    push(u + 12, 3'b111, 1'b1, 3'b000);
    go_to(u + 13);

    // Drain: every expected event must have been observed
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    total = total + 1;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: %0d expected events not seen, expected 0", sb.size());
    end
    repeat (10) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
